// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole engine: state encoding, LFSR
// constants and the half-hole masks lit during fever.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_FEVER = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form: polynomial taps 16/14/13/11 land on bits 0/2/3/5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lower_half_mask(input int n);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < n / 2) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [15:0] upper_half_mask(input int n);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i >= n / 2 && i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/whack_if.sv
// Keypad/lamp/score bundle between the game engine and the pin/display side.
interface whack_if #(
    parameter int N_HOLES = 8,
    parameter int SCORE_W = 8
);
    logic                 start;
    logic [N_HOLES-1:0]   key;
    logic [N_HOLES-1:0]   mole;
    logic [SCORE_W-1:0]   score;
    logic [3:0]           combo;
    logic [7:0]           rounds_left;
    logic                 fever;
    logic                 game_over;
    logic                 hit_pulse;
    logic                 miss_pulse;

    modport master (
        output start, key,
        input  mole, score, combo, rounds_left, fever, game_over, hit_pulse, miss_pulse
    );

    modport slave (
        input  start, key,
        output mole, score, combo, rounds_left, fever, game_over, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/key_edge_sync.sv
// Per-key 2-flop synchroniser, rising-edge detect and a round latch that
// remembers which keys were struck since the last clear.
module key_edge_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] key_in,
    input  logic             clr,
    output logic [WIDTH-1:0] latch
);
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;
    logic [WIDTH-1:0] latch_q, latch_d;
    logic [WIDTH-1:0] rise;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        // A clear drops old hits but keeps a same-cycle edge for the next round.
        latch_d = clr ? rise : (latch_q | rise);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            latch_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            latch_q <= latch_d;
        end
    end

    assign latch = latch_q;
endmodule

// File: rtl/whack_core.sv
// Whack-a-mole engine: LFSR-driven mole lamps, per-round key scoring,
// combo tracking, timed fever mode and fixed-length games.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_PLAY  | normal rounds, random moles
//   ST_FEVER | bonus rounds, alternating half masks
//   ST_OVER  | game finished, all lamps lit, score frozen
module whack_core
    import whack_pkg::*;
#(
    parameter int N_HOLES      = 8,
    parameter int GAME_ROUNDS  = 45,
    parameter int TICK_DIV     = 25_000_000,
    parameter int FEVER_COMBO  = 10,
    parameter int FEVER_ROUNDS = 5,
    parameter int NORMAL_PTS   = 1,
    parameter int FEVER_PTS    = 3,
    parameter int SCORE_W      = 8
) (
    input  logic   clk,
    input  logic   RESET,
    whack_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]      PRESC_LAST     = PW'(TICK_DIV - 1);
    localparam logic [N_HOLES-1:0] MASK_LO        = N_HOLES'(lower_half_mask(N_HOLES));
    localparam logic [N_HOLES-1:0] MASK_HI        = N_HOLES'(upper_half_mask(N_HOLES));
    localparam logic [3:0]         FEVER_COMBO_C  = 4'(FEVER_COMBO);
    localparam logic [7:0]         FEVER_ROUNDS_C = 8'(FEVER_ROUNDS);
    localparam logic [7:0]         GAME_ROUNDS_C  = 8'(GAME_ROUNDS);
    localparam logic [SCORE_W:0]   NORMAL_PTS_C   = (SCORE_W + 1)'(NORMAL_PTS);
    localparam logic [SCORE_W:0]   FEVER_PTS_C    = (SCORE_W + 1)'(FEVER_PTS);

    state_e               state_q, state_d;
    logic [N_HOLES-1:0]   mole_q, mole_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           combo_q, combo_d, combo_new;
    logic [7:0]           rounds_q, rounds_d;
    logic [7:0]           fever_cnt_q, fever_cnt_d, fcnt_new;
    logic                 hit_q, hit_d, miss_q, miss_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [N_HOLES-1:0]   pat_raw, pattern, key_latch;
    logic                 active, tick, hit, start_go, latch_clr;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + b;
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    assign pat_raw   = lfsr_q[N_HOLES-1:0];
    assign pattern   = (pat_raw == '0) ? N_HOLES'(1) : pat_raw;
    assign active    = (state_q == ST_PLAY) || (state_q == ST_FEVER);
    assign tick      = active && (presc_q == PRESC_LAST);
    assign hit       = |(key_latch & mole_q);
    assign start_go  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign latch_clr = tick || start_go;

    key_edge_sync #(.WIDTH(N_HOLES)) u_keys (
        .clk    (clk),
        .RESET  (RESET),
        .key_in (bus.key),
        .clr    (latch_clr),
        .latch  (key_latch)
    );

    always_comb begin
        state_d     = state_q;
        mole_d      = mole_q;
        score_d     = score_q;
        combo_d     = combo_q;
        rounds_d    = rounds_q;
        fever_cnt_d = fever_cnt_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        combo_new   = '0;
        fcnt_new    = '0;
        presc_d     = '0;
        lfsr_d      = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

        if (active) presc_d = tick ? '0 : presc_q + PW'(1);

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d     = ST_PLAY;
                    score_d     = '0;
                    combo_d     = '0;
                    fever_cnt_d = '0;
                    rounds_d    = GAME_ROUNDS_C;
                    mole_d      = pattern;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    rounds_d = rounds_q - 8'd1;
                    if (hit) begin
                        score_d   = sat_add(score_q, NORMAL_PTS_C);
                        combo_new = (combo_q == 4'hF) ? 4'hF : combo_q + 4'd1;
                        hit_d     = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                    combo_d = combo_new;
                    // The last round outranks a fever trigger on the same tick.
                    if (rounds_d == 8'd0) begin
                        state_d = ST_OVER;
                        mole_d  = '1;
                    end else if (combo_new >= FEVER_COMBO_C) begin
                        state_d     = ST_FEVER;
                        fever_cnt_d = '0;
                        mole_d      = MASK_LO;
                    end else begin
                        mole_d = pattern;
                    end
                end
            end
            ST_FEVER: begin
                if (tick) begin
                    rounds_d = rounds_q - 8'd1;
                    if (hit) begin
                        score_d = sat_add(score_q, FEVER_PTS_C);
                        hit_d   = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                    fcnt_new    = fever_cnt_q + 8'd1;
                    fever_cnt_d = fcnt_new;
                    if (rounds_d == 8'd0) begin
                        state_d = ST_OVER;
                        mole_d  = '1;
                    end else if (fcnt_new == FEVER_ROUNDS_C) begin
                        state_d = ST_PLAY;
                        combo_d = '0;
                        mole_d  = pattern;
                    end else begin
                        mole_d = (mole_q == MASK_LO) ? MASK_HI : MASK_LO;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            mole_q      <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            rounds_q    <= '0;
            fever_cnt_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            mole_q      <= mole_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            rounds_q    <= rounds_d;
            fever_cnt_q <= fever_cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            lfsr_q      <= lfsr_d;
            presc_q     <= presc_d;
        end
    end

    assign bus.mole        = mole_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.rounds_left = rounds_q;
    assign bus.fever       = (state_q == ST_FEVER);
    assign bus.game_over   = (state_q == ST_OVER);
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;
endmodule

// File: tb/tb_whack_core.sv
// Directed bench for whack_core: two instances (8-bit and 4-bit score) share
// stimulus; per-round expectations come from a hand-built table.
module tb_whack_core;
    localparam int NH = 8;
    localparam int TD = 4;
    localparam int GR = 45;
    localparam int MK_PAT = 0, MK_LO = 1, MK_HI = 2, MK_ALL = 3;

    typedef struct {
        int mode;   // 0 no key, 1 strike a lit hole, 2 strike all keys on the tick
        int score;  // unsaturated expected score
        int combo;
        int fever;
        int mk;
        int hit;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [NH-1:0] key = '0;
    logic [15:0]   lfsr_m, lfsr_prev_m;
    logic [NH-1:0] cur_mole;
    int            total = 0;
    int            bad = 0;
    int            hit_cnt = 0;
    int            miss_cnt = 0;
    vec_t          tbl[GR];
    int            n_tbl = 0;

    always #5 clk = ~clk;

    whack_if #(.N_HOLES(NH), .SCORE_W(8)) bus8();
    whack_if #(.N_HOLES(NH), .SCORE_W(4)) bus4();
    assign bus8.start = start;
    assign bus8.key   = key;
    assign bus4.start = start;
    assign bus4.key   = key;

    whack_core #(.N_HOLES(NH), .TICK_DIV(TD), .SCORE_W(8)) dut8 (
        .clk(clk), .RESET(rst), .bus(bus8.slave));
    whack_core #(.N_HOLES(NH), .TICK_DIV(TD), .SCORE_W(4)) dut4 (
        .clk(clk), .RESET(rst), .bus(bus4.slave));

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [NH-1:0] pat_m(input logic [15:0] l);
        return (l[7:0] == 8'd0) ? 8'd1 : l[7:0];
    endfunction

    function automatic logic [NH-1:0] low_bit(input logic [NH-1:0] m);
        for (int i = 0; i < NH; i++) if (m[i]) return NH'(1) << i;
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m      <= 16'hACE1;
            lfsr_prev_m <= 16'hACE1;
        end else begin
            lfsr_prev_m <= lfsr_m;
            lfsr_m      <= lfsr_next(lfsr_m);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus8.hit_pulse)  hit_cnt  <= hit_cnt + 1;
            if (bus8.miss_pulse) miss_cnt <= miss_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input int mode, input int score, input int combo,
                       input int fever, input int mk, input int hit);
        tbl[n_tbl] = '{mode, score, combo, fever, mk, hit};
        n_tbl++;
    endtask

    task automatic run_round(input vec_t v, input int rleft);
        logic [NH-1:0] exp_mole;
        if (v.mode == 1) key = low_bit(cur_mole);
        @(negedge clk);
        key = '0;
        if (v.mode == 2) key = '1;
        @(negedge clk);
        key = '0;
        @(negedge clk);
        @(negedge clk);
        case (v.mk)
            MK_LO:   exp_mole = 8'h0F;
            MK_HI:   exp_mole = 8'hF0;
            MK_ALL:  exp_mole = 8'hFF;
            default: exp_mole = pat_m(lfsr_prev_m);
        endcase
        chk($sformatf("score8 r%0d", GR - rleft), 32'(bus8.score), 32'(v.score > 255 ? 255 : v.score));
        chk($sformatf("score4 r%0d", GR - rleft), 32'(bus4.score), 32'(v.score > 15 ? 15 : v.score));
        chk($sformatf("combo r%0d", GR - rleft), 32'(bus8.combo), 32'(v.combo));
        chk($sformatf("fever r%0d", GR - rleft), 32'(bus8.fever), 32'(v.fever));
        chk($sformatf("mole r%0d", GR - rleft), 32'(bus8.mole), 32'(exp_mole));
        chk($sformatf("hit r%0d", GR - rleft), 32'(bus8.hit_pulse), 32'(v.hit));
        chk($sformatf("miss r%0d", GR - rleft), 32'(bus8.miss_pulse), 32'(1 - v.hit));
        chk($sformatf("rounds r%0d", GR - rleft), 32'(bus8.rounds_left), 32'(rleft));
        chk($sformatf("over r%0d", GR - rleft), 32'(bus8.game_over), 32'(rleft == 0));
        cur_mole = exp_mole;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start rounds", 32'(bus8.rounds_left), 32'(GR));
        chk("start score", 32'(bus8.score), 32'd0);
        chk("start combo", 32'(bus8.combo), 32'd0);
        chk("start over", 32'(bus8.game_over), 32'd0);
        chk("start mole", 32'(bus8.mole), 32'(pat_m(lfsr_prev_m)));
        chk("start mole nonzero", 32'(bus8.mole != '0), 32'd1);
        cur_mole = pat_m(lfsr_prev_m);
    endtask

    initial begin
        int h0, m0;
        vec_t v;

        for (int i = 1; i <= 10; i++) add(1, i, i, i == 10, (i == 10) ? MK_LO : MK_PAT, 1);
        add(1, 13, 10, 1, MK_HI, 1);
        add(1, 16, 10, 1, MK_LO, 1);
        add(1, 19, 10, 1, MK_HI, 1);
        add(1, 22, 10, 1, MK_LO, 1);
        add(1, 25, 0, 0, MK_PAT, 1);
        for (int i = 1; i <= 5; i++) add(0, 25, 0, 0, MK_PAT, 0);
        for (int i = 1; i <= 10; i++) add(1, 25 + i, i, i == 10, (i == 10) ? MK_LO : MK_PAT, 1);
        add(1, 38, 10, 1, MK_HI, 1);
        add(0, 38, 10, 1, MK_LO, 0);
        add(1, 41, 10, 1, MK_HI, 1);
        add(1, 44, 10, 1, MK_LO, 1);
        add(0, 44, 0, 0, MK_PAT, 0);
        // Combo reaches the fever threshold on the final tick: game ends instead.
        for (int i = 1; i <= 10; i++) add(1, 44 + i, i, 0, (i == 10) ? MK_ALL : MK_PAT, 1);

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst mole", 32'(bus8.mole), 32'd0);
        chk("rst score", 32'(bus8.score), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle mole", 32'(bus8.mole), 32'd0);
        chk("idle rounds", 32'(bus8.rounds_left), 32'd0);
        chk("idle combo", 32'(bus8.combo), 32'd0);
        chk("idle fever", 32'(bus8.fever), 32'd0);
        chk("idle over", 32'(bus8.game_over), 32'd0);
        chk("idle pulses", 32'({bus8.hit_pulse, bus8.miss_pulse}), 32'd0);

        // Game 1: table-driven scoring, two fever bouts, fever/final-round clash.
        do_start();
        for (int r = 0; r < GR; r++) run_round(tbl[r], GR - 1 - r);
        repeat (10) @(negedge clk);
        chk("over frozen score", 32'(bus8.score), 32'd54);
        chk("over frozen sat4", 32'(bus4.score), 32'd15);
        chk("over held", 32'(bus8.game_over), 32'd1);
        chk("over mole", 32'(bus8.mole), 32'hFF);
        chk("over fever", 32'(bus8.fever), 32'd0);

        // Game 2: no key presses; start during play must be ignored.
        do_start();
        h0 = hit_cnt;
        m0 = miss_cnt;
        for (int r = 1; r <= GR; r++) begin
            if (r == 2) start = 1'b1;
            v = '{0, 0, 0, 0, (r == GR) ? MK_ALL : MK_PAT, 0};
            run_round(v, GR - r);
            start = 1'b0;
        end
        @(negedge clk);
        chk("g2 miss count", 32'(miss_cnt - m0), 32'(GR));
        chk("g2 hit count", 32'(hit_cnt - h0), 32'd0);

        // Game 3: key edge on the tick credits the next round only, then reset in fever.
        do_start();
        for (int r = 1; r <= 3; r++) run_round('{0, 0, 0, 0, MK_PAT, 0}, GR - r);
        run_round('{2, 0, 0, 0, MK_PAT, 0}, GR - 4);
        run_round('{0, 1, 1, 0, MK_PAT, 1}, GR - 5);
        run_round('{0, 1, 0, 0, MK_PAT, 0}, GR - 6);
        for (int i = 1; i <= 10; i++)
            run_round('{1, 1 + i, i, i == 10, (i == 10) ? MK_LO : MK_PAT, 1}, GR - 6 - i);
        #2 rst = 1'b1;
        #1;
        chk("midrst fever", 32'(bus8.fever), 32'd0);
        chk("midrst score", 32'(bus8.score), 32'd0);
        chk("midrst mole", 32'(bus8.mole), 32'd0);
        chk("midrst combo", 32'(bus8.combo), 32'd0);
        chk("midrst rounds", 32'(bus8.rounds_left), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst over", 32'(bus8.game_over), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
